// File: rtl/iob_regfile_np.sv
// rtl/iob_regfile_np.sv - multi-port register file with registered reads and sequential clear engine
//
// Purpose: 2**ADDR_W x DATA_W register file with N_W write ports and N_R
// registered read ports. A clear engine sweeps every entry to zero after
// reset or on a clr_i pulse. Writes are blocked while it runs, and reads
// return zero.
//
// Optional feature macro: IOB_REGFILE_NP_BYPASS_EN
//   defined   - read of an address written on the same edge returns new data
//   undefined - same case returns the old stored data
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset; overrides cke_i
//   cke_i    clock enable; low freezes all state
//   clr_i    clear request pulse (ignored while busy)
//   busy_o   clear sweep in progress
//   wen_i    per-port write enable
//   waddr_i  packed write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wdata_i  packed write data, port k at [k*DATA_W +: DATA_W]
//   ren_i    per-port read enable
//   raddr_i  packed read addresses, port j at [j*ADDR_W +: ADDR_W]
//   rdata_o  packed registered read data, port j at [j*DATA_W +: DATA_W]

module iob_regfile_np #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 21,
  parameter int N_W    = 2,
  parameter int N_R    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cke_i,
  input  logic                   clr_i,
  output logic                   busy_o,
  input  logic [N_W-1:0]         wen_i,
  input  logic [N_W*ADDR_W-1:0]  waddr_i,
  input  logic [N_W*DATA_W-1:0]  wdata_i,
  input  logic [N_R-1:0]         ren_i,
  input  logic [N_R*ADDR_W-1:0]  raddr_i,
  output logic [N_R*DATA_W-1:0]  rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_next [N_R];

  assign busy_o = (state == SWEEP);

  // Read value per port before the enable/sweep gating. With bypass, later
  // (higher-index) matching write ports override earlier ones.
  always_comb begin
    for (int j = 0; j < N_R; j++) begin
      rd_next[j] = mem[raddr_i[j*ADDR_W +: ADDR_W]];
`ifdef IOB_REGFILE_NP_BYPASS_EN
      if (state == IDLE) begin
        for (int k = 0; k < N_W; k++) begin
          if (wen_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] == raddr_i[j*ADDR_W +: ADDR_W]))
            rd_next[j] = wdata_i[k*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= SWEEP;
      cnt     <= '0;
      rdata_o <= '0;
    end else if (cke_i) begin
      for (int j = 0; j < N_R; j++) begin
        if (ren_i[j])
          rdata_o[j*DATA_W +: DATA_W] <= (state == SWEEP) ? '0 : rd_next[j];
      end
      case (state)
        SWEEP: begin
          mem[cnt] <= '0;
          cnt      <= cnt + ADDR_W'(1);
          if (&cnt)
            state <= IDLE;
        end
        default: begin
          // Ascending loop: the last non-blocking assignment wins, so the
          // highest-index port takes a conflicting address.
          for (int k = 0; k < N_W; k++) begin
            if (wen_i[k])
              mem[waddr_i[k*ADDR_W +: ADDR_W]] <= wdata_i[k*DATA_W +: DATA_W];
          end
          if (clr_i) begin
            state <= SWEEP;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_regfile_np.sv
// tb/tb_iob_regfile_np.sv - randomized self-checking bench for iob_regfile_np
module tb_iob_regfile_np;

  localparam int AW = 3;
  localparam int DW = 21;
  localparam int NW = 2;
  localparam int NR = 2;
  localparam int DEPTH = 2 ** AW;

  logic              clk = 1'b0;
  logic              rst, cke, clr;
  logic              busy;
  logic [NW-1:0]     wen;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic [NR-1:0]     ren;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd  [NR];
  int            sweep_left;

  always #5 clk = ~clk;

  iob_regfile_np #(.ADDR_W(AW), .DATA_W(DW), .N_W(NW), .N_R(NR)) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .clr_i(clr), .busy_o(busy),
    .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
    .ren_i(ren), .raddr_i(raddr), .rdata_o(rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_in();
    rst = 0; cke = 1; clr = 0;
    wen = '0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
  endtask

  task automatic set_w(input int k, input int a, input logic [DW-1:0] d);
    wen[k] = 1'b1;
    waddr[k*AW +: AW] = AW'(a);
    wdata[k*DW +: DW] = d;
  endtask

  task automatic set_r(input int j, input int a);
    ren[j] = 1'b1;
    raddr[j*AW +: AW] = AW'(a);
  endtask

  // Model: the sweep is a count of remaining enabled cycles; entries clear in
  // address order. Updates the model from the current inputs, advances one
  // clock, then compares all outputs.
  task automatic tick();
    logic [DW-1:0] v;
    int ra, wa;
    if (rst) begin
      sweep_left = DEPTH;
      for (int j = 0; j < NR; j++) m_rd[j] = '0;
    end else if (cke) begin
      if (sweep_left > 0) begin
        for (int j = 0; j < NR; j++) if (ren[j]) m_rd[j] = '0;
        m_mem[DEPTH - sweep_left] = '0;
        sweep_left--;
      end else begin
        for (int j = 0; j < NR; j++) begin
          if (ren[j]) begin
            ra = int'(raddr[j*AW +: AW]);
            v = m_mem[ra];
`ifdef IOB_REGFILE_NP_BYPASS_EN
            for (int k = 0; k < NW; k++)
              if (wen[k] && int'(waddr[k*AW +: AW]) == ra) v = wdata[k*DW +: DW];
`endif
            m_rd[j] = v;
          end
        end
        for (int k = 0; k < NW; k++) begin
          if (wen[k]) begin
            wa = int'(waddr[k*AW +: AW]);
            m_mem[wa] = wdata[k*DW +: DW];
          end
        end
        if (clr) sweep_left = DEPTH;
      end
    end
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(sweep_left > 0));
    for (int j = 0; j < NR; j++) check("rdata", 32'(rdata[j*DW +: DW]), 32'(m_rd[j]));
  endtask

  // Counts enabled cycles with busy high, with random writes attempted and
  // cke toggling when requested; optional second clr at enabled cycle 3.
  task automatic measure_sweep(input bit toggle_cke, input bit reclr, output int n);
    int guard;
    n = 0; guard = 0;
    while (busy && guard < 60) begin
      idle_in();
      cke = toggle_cke ? guard[0] : 1'b1;
      wen = NW'($urandom);
      waddr = NW*AW'($urandom);
      wdata = {$urandom, $urandom};
      clr = reclr && cke && (n == 3);
      if (cke) n++;
      tick();
      guard++;
    end
    if (guard >= 60) check("sweep_timeout", 32'(guard), 32'(0));
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < DEPTH; a += 2) begin
      idle_in(); set_r(0, a); set_r(1, a + 1);
      tick();
      check("clr_rd0", 32'(rdata[0 +: DW]), 32'(0));
      check("clr_rd1", 32'(rdata[DW +: DW]), 32'(0));
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int j = 0; j < NR; j++) m_rd[j] = '0;
    sweep_left = 0;

    // Reset and initial sweep
    idle_in(); rst = 1; tick(); tick();
    check("rst_busy", 32'(busy), 32'(1));
    check("rst_rdata", 32'(rdata), 32'(0));
    idle_in();
    measure_sweep(1'b0, 1'b0, n);
    check("sweep_len_rst", 32'(n), 32'(DEPTH));
    read_all_zero();

    // Two ports, distinct addresses
    idle_in(); set_w(0, 2, 21'h1AAAA); set_w(1, 5, 21'h05555); tick();
    idle_in(); set_r(0, 2); set_r(1, 5); tick();
    check("dual_wr0", 32'(rdata[0 +: DW]), 32'h1AAAA);
    check("dual_wr1", 32'(rdata[DW +: DW]), 32'h05555);

    // Same address conflict: higher port wins
    idle_in(); set_w(0, 3, 21'h00001); set_w(1, 3, 21'h00002); tick();
    idle_in(); set_r(1, 3); tick();
    check("conflict", 32'(rdata[DW +: DW]), 32'h00002);

    // Read during write
    idle_in(); set_w(0, 6, 21'h00011); tick();
    idle_in(); set_w(0, 6, 21'h12345); set_r(0, 6); tick();
`ifdef IOB_REGFILE_NP_BYPASS_EN
    check("rdw_same_edge", 32'(rdata[0 +: DW]), 32'h12345);
`else
    check("rdw_same_edge", 32'(rdata[0 +: DW]), 32'h00011);
`endif
    idle_in(); set_r(0, 6); tick();
    check("rdw_next", 32'(rdata[0 +: DW]), 32'h12345);

    // Fill, clear with toggling cke, second clr ignored
    for (int a = 0; a < DEPTH; a += 2) begin
      idle_in(); set_w(0, a, DW'($urandom)); set_w(1, a + 1, DW'($urandom)); tick();
    end
    idle_in(); clr = 1; tick();
    check("clr_busy", 32'(busy), 32'(1));
    measure_sweep(1'b1, 1'b1, n);
    check("sweep_len_clr", 32'(n - 1), 32'(DEPTH - 1));
    read_all_zero();

    // Reset at sweep cycle 4 restarts the sweep
    idle_in(); set_w(0, 1, 21'h0ABCD); tick();
    idle_in(); clr = 1; tick();
    for (int i = 0; i < 3; i++) begin idle_in(); tick(); end
    idle_in(); rst = 1; tick();
    idle_in();
    measure_sweep(1'b0, 1'b0, n);
    check("sweep_len_restart", 32'(n), 32'(DEPTH));

    // cke low freezes everything
    idle_in(); set_w(0, 4, 21'h0F0F0); tick();
    idle_in(); set_r(0, 4); tick();
    idle_in(); cke = 0; clr = 1; set_w(0, 4, 21'h11111); set_w(1, 7, 21'h22222);
    set_r(0, 7); set_r(1, 4); tick();
    check("cke_busy", 32'(busy), 32'(0));
    check("cke_rdata", 32'(rdata[0 +: DW]), 32'h0F0F0);
    idle_in(); set_r(0, 4); tick();
    check("cke_mem", 32'(rdata[0 +: DW]), 32'h0F0F0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      idle_in();
      rst   = ($urandom_range(0, 99) == 0);
      cke   = ($urandom_range(0, 9) != 0);
      clr   = ($urandom_range(0, 39) == 0);
      wen   = NW'($urandom);
      waddr = NW*AW'($urandom);
      wdata = {$urandom, $urandom};
      ren   = NR'($urandom);
      raddr = NR*AW'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
